mul_share_ctrl: RTL and testbench

- Sequencer and round-robin arbiter that shares one `multiplier` instance (M=26 unsigned × NS=14 signed, product M+NS bits) among NREQ requesters.
- The multiplier's stage taps and sign logic read the live operand inputs. Its operands must therefore be held stable for LAT clock edges before the product is valid.
- This block holds the operands, times the operation, fixes the zero/negative product encoding, and returns the tagged result.

---
 rtl/mul_share_ctrl.sv | 93 +++++++++
 tb/tb_mul_share_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin sharing of one slow multiplier with held operands, clamp and zero fix.
module mul_share_ctrl #(
    parameter int M    = 26,
    parameter int NS   = 14,
    parameter int NREQ = 2,
    parameter int IDW  = 1,
    parameter int LAT  = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*M-1:0]    req_a,
    input  logic [NREQ*NS-1:0]   req_b,
    output logic [M-1:0]         mul_a,
    output logic [NS-1:0]        mul_b,
    input  logic [M+NS-1:0]      mul_product,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [M+NS-1:0]      rsp_product,
    output logic                 rsp_clamped,
    output logic                 busy
);
    localparam int P  = M + NS;
    localparam int CW = $clog2(LAT + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          state, state_n;
    logic [IDW-1:0]  last_grant, win, id_q;
    logic            any, clamp, clamp_q, accept;
    logic [CW-1:0]   cnt;
    logic [M-1:0]    win_a;
    logic [NS-1:0]   win_b;
    always_comb begin
        win = '0;
        any = 1'b0;
        // descending scan so the nearest requester after last_grant wins
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(last_grant) + k) % NREQ]) begin
                win = IDW'((int'(last_grant) + k) % NREQ);
                any = 1'b1;
            end
        end
    end
    assign accept    = state == IDLE && any;
    assign req_ready = accept ? NREQ'(1) << win : '0;
    assign win_a     = req_a[int'(win)*M +: M];
    assign win_b     = req_b[int'(win)*NS +: NS];
    assign clamp     = win_b == {1'b1, {(NS-1){1'b0}}};
    assign busy      = state != IDLE;
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (any ? RUN : IDLE) :
                  state == RUN  ? (cnt == CW'(1) ? DONE : RUN) :
                                  (rsp_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= IDW'(NREQ - 1);
            id_q        <= '0;
            clamp_q     <= 1'b0;
            cnt         <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
            rsp_clamped <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                mul_a      <= win_a;
                mul_b      <= clamp ? {1'b1, {(NS-2){1'b0}}, 1'b1} : win_b;
                id_q       <= win;
                clamp_q    <= clamp;
                last_grant <= win;
                cnt        <= CW'(LAT);
            end
            if (state == RUN) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    // a zero product with negative b arrives as the sign bit alone
                    rsp_product <= mul_product == {1'b1, {(P-1){1'b0}}} ? '0 : mul_product;
                    rsp_clamped <= clamp_q;
                    rsp_id      <= id_q;
                    rsp_valid   <= 1'b1;
                end
            end
            if (state == DONE && rsp_ready) rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: scoreboard bench with a timing-accurate multiplier model and randomized requesters.
module tb_mul_share_ctrl;
    localparam int M = 26, NS = 14, NREQ = 2, IDW = 1, LAT = 26, P = M + NS;
    logic              clk = 0, rst = 1;
    logic [NREQ-1:0]   req_valid = '0, req_ready;
    logic [NREQ*M-1:0] req_a = '0;
    logic [NREQ*NS-1:0] req_b = '0;
    logic [M-1:0]      mul_a;
    logic [NS-1:0]     mul_b;
    logic [P-1:0]      mul_product, rsp_product;
    logic              rsp_valid, rsp_ready = 1, rsp_clamped, busy;
    logic [IDW-1:0]    rsp_id;

    mul_share_ctrl #(.M(M), .NS(NS), .NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_product(rsp_product), .rsp_clamped(rsp_clamped), .busy(busy));

    always #5 clk = ~clk;

    int vec = 0, errs = 0, n = 0;
    bit was_rst = 0, started = 0;

    // multiplier: correct only once operands have been stable long enough, garbage otherwise
    logic [M-1:0]  pa;
    logic [NS-1:0] pb;
    int            stab = 0;
    longint        mp;
    always @(negedge clk) begin
        stab = (mul_a === pa && mul_b === pb) ? stab + 1 : 0;
        pa = mul_a;
        pb = mul_b;
    end
    always_comb begin
        mp = longint'(mul_a) * longint'($signed(mul_b));
        mul_product = (mp == 0 && mul_b[NS-1]) ? {1'b1, {(P-1){1'b0}}} : mp[P-1:0];
        if (stab < LAT - 1 || mul_b == {1'b1, {(NS-1){1'b0}}}) mul_product = ~mul_product;
    end

    typedef struct {
        int           id;
        logic [M-1:0] a;
        logic [NS-1:0] b;
        logic [P-1:0] prod;
        bit           clamp;
    } item_t;
    item_t exp_q[$];
    bit    inflight = 0;
    int    acc = 0, lg = NREQ - 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, n);
        end
    endtask

    function automatic logic [NREQ-1:0] rr(logic [NREQ-1:0] v, int last);
        for (int k = 1; k <= NREQ; k++)
            if (v[(last + k) % NREQ]) return NREQ'(1) << ((last + k) % NREQ);
        return '0;
    endfunction

    always @(posedge clk) begin
        n++;
        was_rst = rst;
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] g;
        bit ev;
        item_t it;
        if (was_rst) begin
            started = 1;
            chk("rst_id", 64'(rsp_id), 0);
            chk("rst_product", 64'(rsp_product), 0);
            chk("rst_clamped", 64'(rsp_clamped), 0);
            chk("rst_mul_a", 64'(mul_a), 0);
            chk("rst_mul_b", 64'(mul_b), 0);
            exp_q.delete();
            inflight = 0;
            lg = NREQ - 1;
        end
        if (started) begin
            chk("busy", 64'(busy), 64'(inflight));
            ev = inflight && (n - acc >= LAT);
            chk("rsp_valid", 64'(rsp_valid), 64'(ev));
            if (inflight && exp_q.size() > 0) begin
                chk("mul_a", 64'(mul_a), 64'(exp_q[0].a));
                chk("mul_b", 64'(mul_b), 64'(exp_q[0].b));
                if (ev) begin
                    chk("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
                    chk("rsp_product", 64'(rsp_product), 64'(exp_q[0].prod));
                    chk("rsp_clamped", 64'(rsp_clamped), 64'(exp_q[0].clamp));
                end
            end
            g = inflight ? '0 : rr(req_valid, lg);
            chk("req_ready", 64'(req_ready), 64'(g));
            if (!rst) begin
                if (ev && rsp_ready) begin
                    void'(exp_q.pop_front());
                    inflight = 0;
                end else if (g != 0) begin
                    longint p;
                    it.id = $clog2(int'(g));
                    it.a = req_a[it.id*M +: M];
                    it.b = req_b[it.id*NS +: NS];
                    it.clamp = $signed(it.b) == -(2 ** (NS - 1));
                    if (it.clamp) it.b = NS'(-(2 ** (NS - 1) - 1));
                    p = longint'(it.a) * longint'($signed(it.b));
                    it.prod = p[P-1:0];
                    exp_q.push_back(it);
                    inflight = 1;
                    acc = n + 1;
                    lg = it.id;
                end
            end
        end
    end

    task automatic set_op(int i, logic [M-1:0] a, logic [NS-1:0] b);
        req_a[i*M +: M] = a;
        req_b[i*NS +: NS] = b;
        req_valid[i] = 1'b1;
    endtask

    task automatic op(int i, logic [M-1:0] a, logic [NS-1:0] b);
        bit got = 0;
        set_op(i, a, b);
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            got = req_ready[i];
        end
        if (!got) begin
            vec++;
            errs++;
            $display("FAIL grant_timeout: requester %0d got no grant, required within 300 cycles", i);
        end
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int t = 0; t < 300 && !idle; t++) begin
            @(negedge clk);
            idle = !busy;
        end
        if (!idle) begin
            vec++;
            errs++;
            $display("FAIL idle_timeout: busy stuck at 1, required 0 within 300 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        op(0, 1000, -14'sd3);
        wait_idle();
        op(0, 0, -14'sd5);
        op(1, 123, 0);
        op(0, 10, 14'h2000);
        wait_idle();
        rsp_ready = 0;
        op(1, 777, -14'sd100);
        set_op(0, 5, 7);
        repeat (40) @(posedge clk);
        #1 rsp_ready = 1;
        op(0, 5, 7);
        wait_idle();
        set_op(0, 5, 7);
        set_op(1, {M{1'b1}}, 14'd8191);
        repeat (4 * (LAT + 2) + 5) @(posedge clk);
        #1 req_valid = '0;
        wait_idle();
        op(0, 3, 4);
        repeat (9) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        set_op(0, 11, -14'sd2);
        set_op(1, 12, 14'd3);
        @(posedge clk);
        #1 req_valid = '0;
        wait_idle();
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(3) == 0) begin
                for (int i = 0; i < NREQ; i++) begin
                    logic [M-1:0] a;
                    logic [NS-1:0] b;
                    case ($urandom_range(4))
                        0: b = 14'h2000;
                        1: b = 0;
                        2: b = 14'h3fff;
                        3: b = 14'h1fff;
                        default: b = NS'($urandom);
                    endcase
                    case ($urandom_range(3))
                        0: a = 0;
                        1: a = {M{1'b1}};
                        default: a = M'($urandom);
                    endcase
                    req_a[i*M +: M] = a;
                    req_b[i*NS +: NS] = b;
                    req_valid[i] = $urandom_range(1);
                end
            end
            rsp_ready = $urandom_range(3) != 0;
            rst = $urandom_range(599) == 0;
        end
        rst = 0;
        rsp_ready = 1;
        req_valid = '0;
        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
